// File: rtl/trivium_keystream_gen.sv
// Trivium keystream producer: key/IV load, warm-up rounds, then keystream bytes
// pushed into a downstream byte FIFO with a write/full handshake.
module trivium_keystream_gen #(
  parameter int WARMUP_ROUNDS = 1152,
  parameter int LEN_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [79:0]      key,
  input  logic [79:0]      iv,
  input  logic [LEN_W-1:0] nbytes,
  input  logic             fifo_full,
  output logic             write,
  output logic [7:0]       dout,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  // Handshake: a byte is transferred on every rising edge where write is 1,
  // write = byte_vld & ~fifo_full; while byte_vld & fifo_full, dout and the
  // cipher state hold until the FIFO frees up.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    GEN    = 2'd2
  } state_t;

  localparam logic [10:0] RND_LAST = 11'(WARMUP_ROUNDS - 1);

  state_t           state;
  logic [288:1]     s;
  logic [10:0]      rnd_cnt;
  logic [2:0]       bit_cnt;
  logic [6:0]       shreg;
  logic [LEN_W-1:0] byte_cnt;
  logic [LEN_W-1:0] nbytes_r;
  logic             byte_vld;

  logic             t1, t2, t3, z;
  logic [288:1]     s_next;
  logic [288:1]     s_load;
  logic [LEN_W-1:0] byte_cnt_inc;
  logic             fin;
  logic             advance;

  // Key bit K1 is key[79] but lands in s1, so both vectors are bit-reversed.
  function automatic logic [80:1] rev80(input logic [79:0] x);
    logic [80:1] r;
    for (int i = 1; i <= 80; i++) r[i] = x[80-i];
    return r;
  endfunction

  always_comb begin
    t1 = s[66] ^ s[93];
    t2 = s[162] ^ s[177];
    t3 = s[243] ^ s[288];
    z  = t1 ^ t2 ^ t3;
    t1 = t1 ^ (s[91] & s[92]) ^ s[171];
    t2 = t2 ^ (s[175] & s[176]) ^ s[264];
    t3 = t3 ^ (s[286] & s[287]) ^ s[69];
    s_next = {s[287:178], t2, s[176:94], t1, s[92:1], t3};
  end

  assign s_load = {3'b111, 112'd0, rev80(iv), 13'd0, rev80(key)};

  // fin marks the pending byte as the last one requested; no rounds follow it.
  assign byte_cnt_inc = byte_cnt + LEN_W'(1);
  assign fin     = (nbytes_r != '0) && byte_vld && (byte_cnt_inc == nbytes_r);
  assign advance = (state == GEN) && !(byte_vld && fifo_full) && !fin;

  assign write     = byte_vld & ~fifo_full;
  assign done      = write & fin & ~stop;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      s        <= '0;
      rnd_cnt  <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      byte_cnt <= '0;
      nbytes_r <= '0;
      byte_vld <= 1'b0;
      dout     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            s        <= s_load;
            rnd_cnt  <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            nbytes_r <= nbytes;
            byte_vld <= 1'b0;
            state    <= WARMUP;
          end
        end
        WARMUP: begin
          if (stop) begin
            state <= IDLE;
          end else begin
            s       <= s_next;
            rnd_cnt <= rnd_cnt + 11'd1;
            if (rnd_cnt == RND_LAST) begin
              state   <= GEN;
              bit_cnt <= '0;
            end
          end
        end
        GEN: begin
          if (stop) begin
            state    <= IDLE;
            byte_vld <= 1'b0;
          end else begin
            if (write) begin
              byte_vld <= 1'b0;
              byte_cnt <= byte_cnt_inc;
              if (fin) state <= IDLE;
            end
            if (advance) begin
              s       <= s_next;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                dout     <= {shreg, z};
                byte_vld <= 1'b1;
              end else begin
                shreg <= {shreg[5:0], z};
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
